alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer and arbiter that shares the single combinational ALU between two requesters (e.g. the integer pipe and a future address/loop unit). It accepts operations over a valid/ready request handshake, grants round-robin, holds the ALU operands and control stable for an op-dependent number of cycles, then returns result and flags on a shared valid/ready response channel. When idle it drives the ALU with the no-op code so the ALU result never changes spuriously.

## Interface
- WIDTH, 64, operand/result width
- MUL_LAT, 4, execute cycles for MUL (>=1)
- DIV_LAT, 8, execute cycles for DIV (>=1)

- clk  in  1  clock; synchronous reset, active-high
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  bit i: requester i has an op
- req_ready  out  2  bit i: op of requester i accepted this cycle
- req_op  in  8  [4i+3:4i] ALU code of requester i
- req_a  in  2*WIDTH  [WIDTH*i +: WIDTH] operand 1 of requester i
- req_b  in  2*WIDTH  [WIDTH*i +: WIDTH] operand 2 of requester i
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_id  out  1  requester the response belongs to
- resp_result  out  WIDTH  ALU result
- resp_zero  out  1  ALU zero flag
- resp_ovf  out  1  ALU overflow flag
- resp_err  out  1  op rejected (illegal code or divide by zero)
- alu_input_1, alu_input_2  out  WIDTH  to ALU operands
- alu_ctrl  out  4  to ALU control
- alu_result  in  WIDTH; alu_zero, alu_ovf  in  1  from ALU

## Operation
- Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0011 DIV, 0110 SUB, 0111 MUL; 1111 NOP (driven when idle, illegal as a request). All others illegal.
- Latency L: MUL -> MUL_LAT, DIV -> DIV_LAT, all other legal ops -> 1.
- States: IDLE, EXEC, RESP.
- IDLE: grant = requester with valid; if both valid, the one not served last (last_grant register). req_ready[grant]=1 combinationally, other bit 0. On accept latch id, op, a, b. Legal op with no error -> EXEC, counter = L. Illegal op, or DIV with b==0 -> RESP directly with result 0, zero 0, ovf 0, err 1; ALU is never driven with that op.
- EXEC: alu_ctrl = latched op, alu_input_1/2 = latched a/b, stable every cycle. Counter decrements; on the cycle it equals 1, capture alu_result/zero/ovf into response regs (err 0), go RESP.
- RESP: resp_valid=1 with all resp_* stable until resp_ready=1; on handshake go IDLE and update last_grant=id. No request accepted in RESP or EXEC (req_ready=00).
- Outside EXEC: alu_ctrl=1111, alu_input_1/2=0.
- last_grant updates on response handshake, including error responses.

## Timing
- Reset: state IDLE, last_grant=1 (requester 0 wins first tie), req_ready=00, resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_ovf=0, resp_err=0, alu_ctrl=1111, alu_input_1/2=0, counter 0.
- Accept in cycle t -> EXEC cycles t+1..t+L -> resp_valid first high in t+L+1. Error ops: resp_valid in t+1.
- Response handshake in cycle r -> IDLE at r+1; earliest next accept r+1. Throughput: one op per L+2 cycles.
- req_valid may drop without acceptance; no state is retained for unaccepted requests.
- resp_ready high before resp_valid has no effect.
- Reset asserted in any state (mid-EXEC, RESP with pending response) wins: next cycle is reset state, in-flight op discarded, no response emitted.

## Test plan
- Requester 0: ADD a=6 b=2 -> req_ready=01 same cycle, alu_ctrl=0010 for 1 cycle, resp_valid 2 cycles after accept, result 8, zero 0, ovf 0, id 0; alu_ctrl back to 1111.
- Both valid after reset: req0 SUB 6,2 and req1 OR 6,2 held -> req0 served first (result 4, id 0), then req1 (result 6, id 1); repeat with both always valid -> strict alternation.
- Req1 MUL 6,2, MUL_LAT=4 -> alu_ctrl=0111 and operands stable exactly 4 cycles, resp_valid at accept+5, result 12; DIV 6,2 -> 8 cycles, result 3.
- Req0 ADD 2 and -2 -> result 0, zero 1; req0 DIV 6,0 -> resp_valid next cycle, err 1, result 0, alu_ctrl stays 1111; op 0101 -> err 1.
- Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=00 throughout, release -> IDLE, new request accepted next cycle.
- Assert rst during MUL EXEC cycle 2 -> next cycle all outputs at reset values, no resp_valid; after release requester 0 wins a tie.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between two requesters.
//               - Requests are accepted over a valid/ready handshake.
//               - When both requesters are valid, grants alternate round-robin.
//               - Operands and control are held steady on the ALU for an
//                 op-dependent number of cycles.
//               - The captured result and flags are returned on a shared
//                 valid/ready response channel.
//               - Illegal codes and divide-by-zero are answered with an error
//                 response and never reach the ALU.
// Ports       : clk, rst               clock, synchronous active-high reset
//               req_valid/req_ready    per-requester request handshake (2 bits)
//               req_op/req_a/req_b     packed per-requester op code and operands
//               resp_*                 response channel (id, result, flags, err)
//               alu_input_1/2,alu_ctrl drive to the ALU
//               alu_result/zero/ovf    returned by the ALU
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH   = 64,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_zero,
  output logic               resp_ovf,
  output logic               resp_err,
  output logic [WIDTH-1:0]   alu_input_1,
  output logic [WIDTH-1:0]   alu_input_2,
  output logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  input  logic               alu_ovf
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  localparam logic [3:0] c_OP_AND = 4'b0000;
  localparam logic [3:0] c_OP_OR  = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_DIV = 4'b0011;
  localparam logic [3:0] c_OP_SUB = 4'b0110;
  localparam logic [3:0] c_OP_MUL = 4'b0111;
  localparam logic [3:0] c_OP_NOP = 4'b1111;

  localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_CW      = $clog2(c_MAX_LAT + 1);
  localparam logic [c_CW-1:0] c_LAT_MUL = c_CW'(MUL_LAT);
  localparam logic [c_CW-1:0] c_LAT_DIV = c_CW'(DIV_LAT);
  localparam logic [c_CW-1:0] c_LAT_ONE = c_CW'(1);

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ovf;
  logic             r_err;

  logic             w_grant;
  logic             w_accept;
  logic [3:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_legal;
  logic             w_reject;
  logic [c_CW-1:0]  w_lat;

  // On a tie the requester not served last wins; otherwise the single
  // valid requester is granted.
  always_comb begin
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = ~req_valid[0];
    end
  end

  assign w_accept  = (r_state == c_ST_IDLE) && (|req_valid);
  assign req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  assign w_sel_op = w_grant ? req_op[7:4] : req_op[3:0];
  assign w_sel_a  = w_grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign w_sel_b  = w_grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  always_comb begin
    w_legal = 1'b0;
    w_lat   = c_LAT_ONE;
    case (w_sel_op)
      c_OP_AND, c_OP_OR, c_OP_ADD, c_OP_SUB: w_legal = 1'b1;
      c_OP_MUL: begin
        w_legal = 1'b1;
        w_lat   = c_LAT_MUL;
      end
      c_OP_DIV: begin
        w_legal = 1'b1;
        w_lat   = c_LAT_DIV;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Rejected ops bypass the ALU entirely and answer with an error response.
  assign w_reject = !w_legal || ((w_sel_op == c_OP_DIV) && (w_sel_b == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= c_OP_NOP;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_res        <= '0;
      r_zero       <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_id <= w_grant;
            r_op <= w_sel_op;
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            if (w_reject) begin
              r_res   <= '0;
              r_zero  <= 1'b0;
              r_ovf   <= 1'b0;
              r_err   <= 1'b1;
              r_state <= c_ST_RESP;
            end else begin
              r_cnt   <= w_lat;
              r_state <= c_ST_EXEC;
            end
          end
        end
        c_ST_EXEC: begin
          r_cnt <= r_cnt - c_LAT_ONE;
          // Result is sampled on the last cycle the operands are held.
          if (r_cnt == c_LAT_ONE) begin
            r_res   <= alu_result;
            r_zero  <= alu_zero;
            r_ovf   <= alu_ovf;
            r_err   <= 1'b0;
            r_state <= c_ST_RESP;
          end
        end
        c_ST_RESP: begin
          if (resp_ready) begin
            r_last_grant <= r_id;
            r_state      <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign resp_valid  = (r_state == c_ST_RESP);
  assign resp_id     = r_id;
  assign resp_result = r_res;
  assign resp_zero   = r_zero;
  assign resp_ovf    = r_ovf;
  assign resp_err    = r_err;

  // Outside execution the ALU sees a no-op with zero operands so its
  // output never toggles spuriously.
  assign alu_ctrl    = (r_state == c_ST_EXEC) ? r_op : c_OP_NOP;
  assign alu_input_1 = (r_state == c_ST_EXEC) ? r_a  : '0;
  assign alu_input_2 = (r_state == c_ST_EXEC) ? r_b  : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU and
//               a reference model of grant order, latency and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int W  = 64;
  localparam int ML = 4;
  localparam int DL = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [7:0]     req_op;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_id;
  logic [W-1:0]   resp_result;
  logic           resp_zero;
  logic           resp_ovf;
  logic           resp_err;
  logic [W-1:0]   alu_input_1;
  logic [W-1:0]   alu_input_2;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic           alu_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int tb_last  = 1;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_ovf(resp_ovf),
    .resp_err(resp_err),
    .alu_input_1(alu_input_1), .alu_input_2(alu_input_2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return (b == '0) ? '0 : a / b;
      4'd6:    return a - b;
      4'd7:    return a * b;
      default: return '0;
    endcase
  endfunction

  function automatic logic ovf_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = alu_fn(op, a, b);
    if (op == 4'd2) return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    if (op == 4'd6) return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return 1'b0;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_input_1, alu_input_2);
    alu_zero   = (alu_result == '0);
    alu_ovf    = ovf_fn(alu_ctrl, alu_input_1, alu_input_2);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: present requests, expect the model's grant, track
  // the execute window, then hold the response for 'hold' cycles.
  task automatic txn(input logic [1:0] vmask, input logic [3:0] op0, input logic [3:0] op1,
                     input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input int hold);
    int           g, lat, waited, execn;
    logic         err, alu_bad, rdy_bad, stab_bad;
    logic [3:0]   op;
    logic [W-1:0] a, b, er;
    req_valid = vmask;
    req_op    = {op1, op0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    g   = (vmask == 2'b11) ? (1 - tb_last) : (vmask[0] ? 0 : 1);
    op  = (g == 1) ? op1 : op0;
    a   = (g == 1) ? a1 : a0;
    b   = (g == 1) ? b1 : b0;
    err = !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7}) || (op == 4'd3 && b == '0);
    lat = (op == 4'd7) ? ML : ((op == 4'd3) ? DL : 1);
    @(negedge clk);
    check("req_ready", 64'(req_ready), (g == 1) ? 64'd2 : 64'd1);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    waited = 0; execn = 0; alu_bad = 1'b0; rdy_bad = 1'b0;
    while (waited < 40) begin
      resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      waited++;
      if (resp_valid) break;
      if (req_ready != 2'b00) rdy_bad = 1'b1;
      if (alu_ctrl == op && alu_input_1 == a && alu_input_2 == b) execn++;
      else alu_bad = 1'b1;
    end
    check("latency", 64'(waited), err ? 64'd1 : 64'(lat + 1));
    check("exec_cycles", 64'(execn), err ? 64'd0 : 64'(lat));
    check("alu_hold", 64'(alu_bad), 64'd0);
    check("busy_ready", 64'(rdy_bad), 64'd0);
    er = err ? '0 : alu_fn(op, a, b);
    check("resp_id", 64'(resp_id), 64'(g));
    check("resp_result", resp_result, er);
    check("resp_zero", 64'(resp_zero), err ? 64'd0 : 64'(er == '0));
    check("resp_ovf", 64'(resp_ovf), err ? 64'd0 : 64'(ovf_fn(op, a, b)));
    check("resp_err", 64'(resp_err), 64'(err));
    check("resp_alu_idle", {alu_ctrl, alu_input_1[29:0], alu_input_2[29:0]}, {4'hF, 60'd0});
    resp_ready = (hold == 0);
    stab_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_result != er || resp_id != 1'(g) || resp_err != err || req_ready != 2'b00)
        stab_bad = 1'b1;
    end
    if (hold > 0) check("resp_stable", 64'(stab_bad), 64'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    tb_last = g;
  endtask

  logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd5, 4'd15, 4'd2, 4'd7};

  initial begin
    logic [W-1:0] ra [4];
    logic         stray;
    rst = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp", {resp_id, resp_zero, resp_ovf, resp_err, resp_result[59:0]}, 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'hF);
    check("rst_alu_in", alu_input_1 | alu_input_2, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    txn(2'b01, 4'd2, 4'd0, 64'd6, 64'd2, 64'd0, 64'd0, 0);
    txn(2'b11, 4'd6, 4'd1, 64'd6, 64'd2, 64'd6, 64'd2, 0);
    txn(2'b11, 4'd6, 4'd1, 64'd6, 64'd2, 64'd6, 64'd2, 0);
    txn(2'b11, 4'd6, 4'd1, 64'd6, 64'd2, 64'd6, 64'd2, 1);
    txn(2'b11, 4'd6, 4'd1, 64'd6, 64'd2, 64'd6, 64'd2, 0);
    txn(2'b10, 4'd0, 4'd7, 64'd0, 64'd0, 64'd6, 64'd2, 0);
    txn(2'b10, 4'd0, 4'd3, 64'd0, 64'd0, 64'd6, 64'd2, 0);
    txn(2'b01, 4'd2, 4'd0, 64'd2, -64'sd2, 64'd0, 64'd0, 0);
    txn(2'b01, 4'd3, 4'd0, 64'd6, 64'd0, 64'd0, 64'd0, 0);
    txn(2'b01, 4'd5, 4'd0, 64'd6, 64'd2, 64'd0, 64'd0, 0);
    txn(2'b01, 4'd2, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5);

    // Reset during the second MUL execute cycle
    req_valid = 2'b10; req_op = {4'd7, 4'd0}; req_a = {64'd6, 64'd0}; req_b = {64'd2, 64'd0};
    @(negedge clk);
    check("mul_ready", 64'(req_ready), 64'd2);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("mul_exec2_ctrl", 64'(alu_ctrl), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_alu_ctrl", 64'(alu_ctrl), 64'hF);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_resp", {resp_id, resp_err, resp_result[61:0]}, 64'd0);
    rst = 1'b0;
    tb_last = 1;
    stray = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid || alu_ctrl != 4'hF) stray = 1'b1;
    end
    check("no_resp_after_rst", 64'(stray), 64'd0);
    @(posedge clk);
    #1;
    txn(2'b11, 4'd2, 4'd1, 64'd1, 64'd1, 64'd3, 64'd4, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       ra[k] = '0;
          1:       ra[k] = 64'($urandom_range(0, 50));
          default: ra[k] = {$urandom, $urandom};
        endcase
      end
      txn(2'($urandom_range(1, 3)), ops[$urandom_range(0, 9)], ops[$urandom_range(0, 9)],
          ra[0], ra[1], ra[2], ra[3], int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
